// File: rtl/hs32_pkg.sv
// Shared types for the hs32 memory arbiter: FSM states, master select, bus request payload.
package hs32_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_X = 2'd2
  } state_t;

  typedef enum logic {
    MST_F = 1'b0,
    MST_X = 1'b1
  } mst_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dtw;
    logic          rw;
  } bus_req_t;

endpackage

// File: rtl/hs32_arb_pick.sv
// Combinational master selector. Define HS32_ARB_FAIR_EN for alternating tie-break,
// otherwise execute always wins a tie.
module hs32_arb_pick
  import hs32_pkg::*;
(
  input  logic stbf,
  input  logic stbx,
  input  mst_t last,
  output logic grant,
  output mst_t mst
);

`ifdef HS32_ARB_FAIR_EN
  always_comb begin
    grant = stbf | stbx;
    mst   = MST_F;
    if (stbf && stbx)
      mst = (last == MST_F) ? MST_X : MST_F;
    else if (stbx)
      mst = MST_X;
  end
`else
  logic unused_last;
  assign unused_last = logic'(last);

  always_comb begin
    grant = stbf | stbx;
    mst   = stbx ? MST_X : MST_F;
  end
`endif

endmodule

// File: rtl/hs32_mem_arbiter.sv
// Single-port memory arbiter between fetch and execute masters.
// Tie-break policy selected in hs32_arb_pick by HS32_ARB_FAIR_EN.
module hs32_mem_arbiter
  import hs32_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [AW-1:0] addrf,
  input  logic          stbf,
  output logic [DW-1:0] dtrf,
  output logic          ackf,
  output logic          stlf,
  input  logic [AW-1:0] addrx,
  input  logic [DW-1:0] dtwx,
  input  logic          rwx,
  input  logic          stbx,
  output logic [DW-1:0] dtrx,
  output logic          ackx,
  output logic          stlx,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dtw,
  output logic          rw,
  output logic          stb,
  input  logic [DW-1:0] dtr,
  input  logic          ack
);

  state_t        state, state_nxt;
  logic          discard, discard_nxt;
  bus_req_t      bus_nxt;
  logic          stb_nxt, ackf_nxt, ackx_nxt, stlf_nxt, stlx_nxt;
  logic [DW-1:0] dtrf_nxt, dtrx_nxt;
  logic          fetch_req_c;
  logic          grant_c;
  mst_t          mst_c;
  mst_t          last;

  // A fetch strobe coincident with flush belongs to the squashed path.
  assign fetch_req_c = stbf & ~flush;

  hs32_arb_pick u_pick (
    .stbf  (fetch_req_c),
    .stbx  (stbx),
    .last  (last),
    .grant (grant_c),
    .mst   (mst_c)
  );

`ifdef HS32_ARB_FAIR_EN
  always_ff @(posedge clk) begin
    if (!reset)
      last <= MST_F;
    else if (state == IDLE && grant_c)
      last <= mst_c;
  end
`else
  assign last = MST_F;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      discard <= 1'b0;
      addr    <= '0;
      dtw     <= '0;
      rw      <= 1'b0;
      stb     <= 1'b0;
      ackf    <= 1'b0;
      ackx    <= 1'b0;
      stlf    <= 1'b0;
      stlx    <= 1'b0;
      dtrf    <= '0;
      dtrx    <= '0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
      addr    <= bus_nxt.addr;
      dtw     <= bus_nxt.dtw;
      rw      <= bus_nxt.rw;
      stb     <= stb_nxt;
      ackf    <= ackf_nxt;
      ackx    <= ackx_nxt;
      stlf    <= stlf_nxt;
      stlx    <= stlx_nxt;
      dtrf    <= dtrf_nxt;
      dtrx    <= dtrx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    bus_nxt     = '{addr: addr, dtw: dtw, rw: rw};
    stb_nxt     = 1'b0;
    ackf_nxt    = 1'b0;
    ackx_nxt    = 1'b0;
    stlf_nxt    = 1'b0;
    stlx_nxt    = 1'b0;
    dtrf_nxt    = dtrf;
    dtrx_nxt    = dtrx;

    unique case (state)
      IDLE: begin
        discard_nxt = 1'b0;
        if (grant_c) begin
          stb_nxt = 1'b1;
          if (mst_c == MST_X) begin
            bus_nxt   = '{addr: addrx, dtw: dtwx, rw: rwx};
            state_nxt = BUSY_X;
            stlf_nxt  = fetch_req_c;
          end else begin
            bus_nxt.addr = addrf;
            bus_nxt.rw   = 1'b0;
            state_nxt    = BUSY_F;
            stlx_nxt     = stbx;
          end
        end
      end
      BUSY_F: begin
        if (flush)
          discard_nxt = 1'b1;
        if (ack) begin
          // Same-cycle flush also squashes the response.
          if (!(discard || flush)) begin
            dtrf_nxt = dtr;
            ackf_nxt = 1'b1;
          end
          discard_nxt = 1'b0;
          state_nxt   = IDLE;
        end
        stlf_nxt = fetch_req_c & ~ackf_nxt;
        stlx_nxt = stbx;
      end
      BUSY_X: begin
        if (ack) begin
          dtrx_nxt  = dtr;
          ackx_nxt  = 1'b1;
          state_nxt = IDLE;
        end
        stlf_nxt = fetch_req_c;
        stlx_nxt = stbx & ~ackx_nxt;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
